vec_mul_sequencer: RTL and testbench

//   Control FSM for the 8x8 vector-multiply datapath. Per job, it drains one weight tile from the Weight FIFO,

---
 rtl/vec_mul_pkg.sv | 22 ++
 rtl/vec_mul_sequencer_if.sv | 35 +++
 rtl/vec_mul_sequencer_valid_delay_line.sv | 43 ++++
 rtl/vec_mul_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_vec_mul_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiply sequencer: state encoding and default geometry.
package vec_mul_pkg;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_CNT_W       = 11;
    localparam int DEF_PIPE_LAT    = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WLOAD   = 3'd1,
        WRELOAD = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } seq_state_e;

    function automatic logic is_active(input seq_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// Job-control, Weight FIFO, Unified Buffer read and Results SRAM write signals of the sequencer.
interface vec_mul_sequencer_if #(
    parameter int ADDRESSSIZE = vec_mul_pkg::DEF_ADDRESSSIZE,
    parameter int CNT_W       = vec_mul_pkg::DEF_CNT_W
) ();

    logic                   start;
    logic                   abort;
    logic                   reuse_weights;
    logic [ADDRESSSIZE-1:0] src_base;
    logic [ADDRESSSIZE-1:0] dst_base;
    logic [CNT_W-1:0]       num_vec;
    logic                   fifo_empty;
    logic                   fifo_read_enable;
    logic                   weight_reload;
    logic [ADDRESSSIZE-1:0] sram_address;
    logic                   sram_rd_valid;
    logic                   result_we;
    logic [ADDRESSSIZE-1:0] result_address;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, abort, reuse_weights, src_base, dst_base, num_vec, fifo_empty,
        output fifo_read_enable, weight_reload, sram_address, sram_rd_valid,
               result_we, result_address, busy, done
    );

    modport slave (
        output start, abort, reuse_weights, src_base, dst_base, num_vec, fifo_empty,
        input  fifo_read_enable, weight_reload, sram_address, sram_rd_valid,
               result_we, result_address, busy, done
    );

endinterface

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
// Shift register that carries each UB read-valid forward to the matching Results SRAM write.
module valid_delay_line
    import vec_mul_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic any_set
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Next shift-register contents; clr discards every in-flight valid
    always_comb begin
        sr_d = {DEPTH{1'b0}};
        if (clr) begin
            sr_d = {DEPTH{1'b0}};
        end else begin
            sr_d[0] = din;
            for (int j = 1; j < DEPTH; j++) begin
                sr_d[j] = sr_q[j-1];
            end
        end
    end

    // Shift-register state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q <= {DEPTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout    = sr_q[DEPTH-1];
    assign any_set = |sr_q;

endmodule

// File: rtl/vec_mul_sequencer.sv
// Job sequencer for the 8x8 vector-multiply datapath: weight tile load, vector streaming,
// fixed-latency result write-back and completion signalling.
module vec_mul_sequencer
    import vec_mul_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
    input  logic                clk,
    input  logic                rstn,
    vec_mul_sequencer_if.master bus
);

    localparam int                     RCNT_W     = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [RCNT_W-1:0]      RCNT_ZERO  = {RCNT_W{1'b0}};
    localparam logic [RCNT_W-1:0]      RCNT_ONE   = RCNT_W'(1);
    localparam logic [RCNT_W-1:0]      RCNT_LAST  = RCNT_W'(MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic [ADDRESSSIZE-1:0] ADDR_ZERO  = {ADDRESSSIZE{1'b0}};

    seq_state_e             state_q, state_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    logic [CNT_W-1:0]       i_q, i_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]       num_vec_q, num_vec_d;
    logic [ADDRESSSIZE-1:0] src_base_q, src_base_d;
    logic [ADDRESSSIZE-1:0] dst_base_q, dst_base_d;
    logic [ADDRESSSIZE-1:0] sram_address_q, sram_address_d;
    logic [ADDRESSSIZE-1:0] result_address_q, result_address_d;
    logic                   sram_rd_valid_q, sram_rd_valid_d;
    logic                   weight_reload_q, weight_reload_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pop_s;
    logic                   result_we_s;
    logic                   pending_s;

    // The pop is the only combinational output so an available row is taken in the same cycle
    assign pop_s = (state_q == WLOAD) && !bus.fifo_empty && !bus.abort;

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay_line (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (bus.abort),
        .din     (sram_rd_valid_q),
        .dout    (result_we_s),
        .any_set (pending_s)
    );

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        i_d        = i_q;
        num_vec_d  = num_vec_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        if (result_we_s) begin
            k_d = k_q + CNT_ONE;
        end else begin
            k_d = k_q;
        end

        if (bus.abort) begin
            state_d = IDLE;
            rcnt_d  = RCNT_ZERO;
            i_d     = CNT_ZERO;
            k_d     = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        num_vec_d  = bus.num_vec;
                        src_base_d = bus.src_base;
                        dst_base_d = bus.dst_base;
                        rcnt_d     = RCNT_ZERO;
                        i_d        = CNT_ZERO;
                        k_d        = CNT_ZERO;
                        if (bus.num_vec == CNT_ZERO) begin
                            state_d = DONE;
                        end else if (bus.reuse_weights) begin
                            state_d = STREAM;
                        end else begin
                            state_d = WLOAD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WLOAD: begin
                    if (pop_s) begin
                        if (rcnt_q == RCNT_LAST) begin
                            rcnt_d  = RCNT_ZERO;
                            state_d = WRELOAD;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_ONE;
                        end
                    end else begin
                        rcnt_d = rcnt_q;
                    end
                end
                WRELOAD: begin
                    state_d = STREAM;
                    i_d     = CNT_ZERO;
                end
                STREAM: begin
                    if (i_q == num_vec_q - CNT_ONE) begin
                        state_d = DRAIN;
                    end else begin
                        i_d = i_q + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (!pending_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    i_d     = CNT_ZERO;
                    k_d     = CNT_ZERO;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they line up with the registered state
        sram_rd_valid_d = (state_d == STREAM);
        weight_reload_d = (state_d == WRELOAD);
        busy_d          = is_active(state_d);
        done_d          = (state_d == DONE);
        if (sram_rd_valid_d) begin
            sram_address_d = src_base_d + ADDRESSSIZE'(i_d);
        end else begin
            sram_address_d = ADDR_ZERO;
        end
        if (state_d == IDLE) begin
            result_address_d = ADDR_ZERO;
        end else begin
            result_address_d = dst_base_d + ADDRESSSIZE'(k_d);
        end
    end

    // FSM state, counters, latched job configuration and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            rcnt_q           <= RCNT_ZERO;
            i_q              <= CNT_ZERO;
            k_q              <= CNT_ZERO;
            num_vec_q        <= CNT_ZERO;
            src_base_q       <= ADDR_ZERO;
            dst_base_q       <= ADDR_ZERO;
            sram_address_q   <= ADDR_ZERO;
            result_address_q <= ADDR_ZERO;
            sram_rd_valid_q  <= 1'b0;
            weight_reload_q  <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            rcnt_q           <= rcnt_d;
            i_q              <= i_d;
            k_q              <= k_d;
            num_vec_q        <= num_vec_d;
            src_base_q       <= src_base_d;
            dst_base_q       <= dst_base_d;
            sram_address_q   <= sram_address_d;
            result_address_q <= result_address_d;
            sram_rd_valid_q  <= sram_rd_valid_d;
            weight_reload_q  <= weight_reload_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign bus.fifo_read_enable = pop_s;
    assign bus.weight_reload    = weight_reload_q;
    assign bus.sram_address     = sram_address_q;
    assign bus.sram_rd_valid    = sram_rd_valid_q;
    assign bus.result_we        = result_we_s;
    assign bus.result_address   = result_address_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer: table of jobs plus abort / ignored-start sequences,
// with a queue scoreboard for UB reads and Results SRAM writes.
module tb_vec_mul_sequencer;

    localparam int L = 10;

    typedef struct {
        int src;
        int dst;
        int n;
        int reuse;
        int stall;
        int lat;
        int pops;
        int reloads;
        int span;
    } job_vec_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   job_pops;
    int   job_reloads;
    int   first_pop;
    int   last_pop;
    int   reload_cyc;
    int   done_cnt;
    int   done_base;
    int   start_cyc;
    int   exp_rd[$];
    int   exp_wr_addr[$];
    int   exp_wr_cyc[$];

    vec_mul_sequencer_if #(.ADDRESSSIZE(10), .CNT_W(11)) bus ();

    vec_mul_sequencer #(
        .ADDRESSSIZE (10),
        .MATRIX_SIZE (8),
        .CNT_W       (11),
        .PIPE_LAT    (L)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.fifo_empty) check("pop_while_empty", int'(bus.fifo_read_enable), 0);
            if (bus.fifo_read_enable) begin
                if (job_pops == 0) first_pop = cyc;
                last_pop = cyc;
                job_pops++;
            end
            if (bus.weight_reload) begin
                job_reloads++;
                reload_cyc = cyc;
                check("reload_after_8_pops", job_pops, 8);
            end
            if (bus.sram_rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read_addr", int'(bus.sram_address), -1);
                end else begin
                    check("rd_addr", int'(bus.sram_address), exp_rd.pop_front());
                    exp_wr_cyc.push_back(cyc + L);
                end
            end
            if (bus.result_we) begin
                if (exp_wr_addr.size() == 0) begin
                    check("unexpected_write_addr", int'(bus.result_address), -1);
                end else begin
                    check("wr_addr", int'(bus.result_address), exp_wr_addr.pop_front());
                    if (exp_wr_cyc.size() == 0) check("wr_cycle", cyc, -1);
                    else check("wr_cycle", cyc, exp_wr_cyc.pop_front());
                end
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic job_begin(input int src, input int dst, input int n, input int reuse);
        job_pops    = 0;
        job_reloads = 0;
        first_pop   = -1;
        last_pop    = -1;
        reload_cyc  = -1;
        done_base   = done_cnt;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back((src + i) % 1024);
            exp_wr_addr.push_back((dst + i) % 1024);
        end
        bus.start         = 1'b1;
        bus.src_base      = 10'(src);
        bus.dst_base      = 10'(dst);
        bus.num_vec       = 11'(n);
        bus.reuse_weights = (reuse != 0);
        start_cyc = cyc;
        step();
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic job_finish(input string tag, input int exp_lat, input int exp_pops,
                              input int exp_reloads, input int exp_span);
        int  waited;
        bit  seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 400) begin
            if (bus.done) seen = 1'b1;
            else begin
                step();
                waited++;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, int'(bus.done), 1);
        else check({tag, "_done_latency"}, cyc - start_cyc, exp_lat);
        step();
        check({tag, "_idle_after_done"}, int'({bus.busy, bus.done}), 0);
        check({tag, "_pops"}, job_pops, exp_pops);
        check({tag, "_reloads"}, job_reloads, exp_reloads);
        if (exp_pops > 0) begin
            check({tag, "_pop_span"}, last_pop - first_pop, exp_span);
            check({tag, "_reload_cycle"}, reload_cyc, last_pop + 1);
        end
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_reads_left"}, exp_rd.size(), 0);
        check({tag, "_writes_left"}, exp_wr_addr.size(), 0);
    endtask

    job_vec_t tbl[6];

    initial begin
        int d0;
        tbl[0] = '{32'h010, 32'h020, 3, 0, 0, 24, 8, 1, 7};
        tbl[1] = '{32'h3FE, 32'h100, 4, 1, 0, 16, 0, 0, 0};
        tbl[2] = '{32'h123, 32'h045, 0, 0, 0, 1,  0, 0, 0};
        tbl[3] = '{32'h100, 32'h3FF, 5, 1, 0, 17, 0, 0, 0};
        tbl[4] = '{32'h055, 32'h0AA, 1, 0, 0, 22, 8, 1, 7};
        tbl[5] = '{32'h200, 32'h300, 2, 0, 1, 26, 8, 1, 10};

        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        job_pops = 0;
        job_reloads = 0;
        rstn              = 1'b0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.reuse_weights = 1'b0;
        bus.src_base      = 10'h000;
        bus.dst_base      = 10'h000;
        bus.num_vec       = 11'd0;
        bus.fifo_empty    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({bus.fifo_read_enable, bus.weight_reload, bus.sram_address,
                                     bus.sram_rd_valid, bus.result_we, bus.result_address,
                                     bus.busy, bus.done}), 0);
        rstn = 1'b1;
        step();
        check("idle_after_reset", int'(bus.busy), 0);

        for (int t = 0; t < 6; t++) begin
            job_begin(tbl[t].src, tbl[t].dst, tbl[t].n, tbl[t].reuse);
            if (tbl[t].stall != 0) begin
                step();
                step();
                bus.fifo_empty = 1'b1;
                step();
                step();
                step();
                bus.fifo_empty = 1'b0;
            end
            job_finish($sformatf("job%0d", t), tbl[t].lat, tbl[t].pops, tbl[t].reloads, tbl[t].span);
        end

        // Abort in DRAIN after two of four writes; restart in the very next cycle
        job_begin(32'h000, 32'h040, 4, 1);
        repeat (11) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_pending_writes", exp_wr_addr.size(), 2);
        check("abort_idle", int'(bus.busy), 0);
        exp_rd.delete();
        exp_wr_addr.delete();
        exp_wr_cyc.delete();
        job_begin(32'h1F0, 32'h200, 2, 1);
        job_finish("post_abort", 14, 0, 0, 0);

        // Start pulsed mid-STREAM with different config is ignored
        job_begin(32'h080, 32'h0C0, 6, 1);
        step();
        step();
        bus.start         = 1'b1;
        bus.src_base      = 10'h3C0;
        bus.num_vec       = 11'd2;
        bus.reuse_weights = 1'b0;
        step();
        bus.start = 1'b0;
        job_finish("start_in_stream", 18, 0, 0, 0);

        // start and abort together in IDLE: job not accepted
        d0 = done_cnt;
        job_pops          = 0;
        bus.start         = 1'b1;
        bus.abort         = 1'b1;
        bus.num_vec       = 11'd3;
        bus.reuse_weights = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_not_busy", int'(bus.busy), 0);
        repeat (20) step();
        check("start_abort_no_done", done_cnt - d0, 0);
        check("start_abort_still_idle", int'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
